// File: rtl/rv32_mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the SRAM array and rv32_mem_arbiter.
// The master side drives requests and SRAM read data; the slave side is the arbiter.
interface rv32_mem_arbiter_if #(
   parameter int XLEN = 32
);
   logic            cpu_req;
   logic [XLEN-1:0] cpu_haddr;
   logic            cpu_hwrite;
   logic [2:0]      cpu_hsize;
   logic [XLEN-1:0] cpu_hwdata;
   logic            cpu_stall;
   logic            dma_req_valid;
   logic            dma_req_ready;
   logic [XLEN-1:0] dma_addr;
   logic            dma_we;
   logic [XLEN-1:0] dma_wdata;
   logic            dma_rsp_valid;
   logic [XLEN-1:0] dma_rdata;
   logic            dma_err;
   logic            sram_we;
   logic [XLEN-1:0] sram_addr;
   logic [2:0]      sram_size;
   logic [XLEN-1:0] sram_wdata;
   logic [XLEN-1:0] sram_rdata;

   modport master (
      output cpu_req, cpu_haddr, cpu_hwrite, cpu_hsize, cpu_hwdata,
      output dma_req_valid, dma_addr, dma_we, dma_wdata, sram_rdata,
      input  cpu_stall, dma_req_ready, dma_rsp_valid, dma_rdata, dma_err,
      input  sram_we, sram_addr, sram_size, sram_wdata
   );

   modport slave (
      input  cpu_req, cpu_haddr, cpu_hwrite, cpu_hsize, cpu_hwdata,
      input  dma_req_valid, dma_addr, dma_we, dma_wdata, sram_rdata,
      output cpu_stall, dma_req_ready, dma_rsp_valid, dma_rdata, dma_err,
      output sram_we, sram_addr, sram_size, sram_wdata
   );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Single-port SRAM arbiter between the RV32IM core and the accelerator DMA, with a
// registered ownership FSM, valid/ready DMA beats and a starvation guard for the CPU.
module rv32_mem_arbiter #(
   parameter int XLEN             = 32,
   parameter int MEM_BYTES        = 65536,
   parameter int MAX_DMA_BEATS    = 16,
   parameter int CPU_YIELD_CYCLES = 2
) (
   input logic              clk,
   input logic              rst,
   rv32_mem_arbiter_if.slave bus
);
   localparam int BEAT_W  = (MAX_DMA_BEATS > 1) ? $clog2(MAX_DMA_BEATS) : 1;
   localparam int YIELD_W = (CPU_YIELD_CYCLES > 1) ? $clog2(CPU_YIELD_CYCLES) : 1;
   localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(MAX_DMA_BEATS - 1);
   localparam logic [YIELD_W-1:0] YIELD_LAST = YIELD_W'(CPU_YIELD_CYCLES - 1);
   localparam logic [XLEN-1:0]    MEM_LIMIT  = XLEN'(MEM_BYTES);

   typedef enum logic [1:0] {S_CPU, S_DMA, S_YIELD} state_t;

   state_t             r_state;
   logic [BEAT_W-1:0]  r_beatCnt;
   logic [YIELD_W-1:0] r_yieldCnt;
   logic               r_rspValid;
   logic               r_rspErr;
   logic [XLEN-1:0]    r_rspData;

   logic w_dmaOwn;
   logic w_inRange;
   logic w_accept;
   logic w_needRsp;

   assign w_dmaOwn  = (r_state == S_DMA);
   assign w_inRange = (bus.dma_addr < MEM_LIMIT);
   assign w_accept  = w_dmaOwn & bus.dma_req_valid;
   // Reads always answer; writes answer only when they were rejected as out of range.
   assign w_needRsp = w_accept & (~bus.dma_we | ~w_inRange);

   assign bus.cpu_stall     = w_dmaOwn;
   assign bus.dma_req_ready = w_dmaOwn;
   assign bus.dma_rsp_valid = r_rspValid;
   assign bus.dma_err       = r_rspErr;
   assign bus.dma_rdata     = r_rspData;

   always_comb begin
      bus.sram_we    = bus.cpu_req & bus.cpu_hwrite;
      bus.sram_addr  = bus.cpu_haddr;
      bus.sram_size  = bus.cpu_hsize;
      bus.sram_wdata = bus.cpu_hwdata;
      if (w_dmaOwn) begin
         bus.sram_we    = bus.dma_req_valid & bus.dma_we & w_inRange;
         bus.sram_addr  = {bus.dma_addr[XLEN-1:2], 2'b00};
         bus.sram_size  = 3'b010;
         bus.sram_wdata = bus.dma_wdata;
      end
   end

   // Ownership FSM; after MAX_DMA_BEATS accepted beats a waiting CPU gets a forced slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_CPU;
         r_beatCnt  <= '0;
         r_yieldCnt <= '0;
      end else begin
         case (r_state)
            S_CPU: begin
               r_beatCnt <= '0;
               if (bus.dma_req_valid)
                  r_state <= S_DMA;
            end
            S_DMA: begin
               if (!bus.dma_req_valid) begin
                  r_state   <= S_CPU;
                  r_beatCnt <= '0;
               end else if (r_beatCnt == BEAT_LAST) begin
                  r_beatCnt <= '0;
                  if (bus.cpu_req) begin
                     r_state    <= S_YIELD;
                     r_yieldCnt <= '0;
                  end
               end else begin
                  r_beatCnt <= r_beatCnt + 1'b1;
               end
            end
            S_YIELD: begin
               if (r_yieldCnt == YIELD_LAST) begin
                  r_yieldCnt <= '0;
                  r_state    <= bus.dma_req_valid ? S_DMA : S_CPU;
               end else begin
                  r_yieldCnt <= r_yieldCnt + 1'b1;
               end
            end
            default: r_state <= S_CPU;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rspValid <= 1'b0;
         r_rspErr   <= 1'b0;
         r_rspData  <= '0;
      end else begin
         r_rspValid <= w_needRsp;
         r_rspErr   <= w_needRsp & ~w_inRange;
         if (w_needRsp)
            r_rspData <= w_inRange ? bus.sram_rdata : '0;
      end
   end
endmodule
